// File: rtl/network_argmax.sv
// Sequential argmax over the NETWORK output layer: captures a vector, scans one element per clock
// and reports index, score and overflow. Optional ARGMAX_MARGIN_EN adds a best-minus-second margin.
module network_argmax #(
    parameter int FP_WIDTH    = 8,
    parameter int FP_FRAC     = 5,
    parameter int NUM_CLASSES = 5,
    localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CLASSES*FP_WIDTH-1:0] values_in,
    input  logic                            valid_in,
    input  logic                            overflow_in,
    output logic [IDX_W-1:0]                class_out,
    output logic [FP_WIDTH-1:0]             score_out,
    output logic                            class_ovf,
    output logic                            class_valid,
    output logic                            busy,
`ifdef ARGMAX_MARGIN_EN
    output logic [FP_WIDTH:0]               margin_out,
`endif
    output logic [7:0]                      drop_count
);

    if (NUM_CLASSES < 2 || FP_FRAC >= FP_WIDTH) begin : g_bad_cfg
        $error("network_argmax: need NUM_CLASSES >= 2 and FP_FRAC < FP_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t state_q, state_nx;

    logic [NUM_CLASSES*FP_WIDTH-1:0] vec_q;
    logic                            ovf_q;
    logic [IDX_W-1:0]                idx_q, best_idx_q, best_idx_nx;
    logic signed [FP_WIDTH-1:0]      best_q, best_nx, elem;
    logic signed [FP_WIDTH-1:0]      elems [NUM_CLASSES];
    logic                            accept, last;
`ifdef ARGMAX_MARGIN_EN
    logic signed [FP_WIDTH-1:0]      second_q, second_nx;
    logic [FP_WIDTH:0]               margin_nx;
`endif

    // valid_in is a one-cycle strobe with no back-pressure: it is taken in IDLE or DONE,
    // and a strobe seen while busy is high is counted in drop_count and otherwise ignored.
    assign accept = valid_in && (state_q != SCAN);
    assign last   = (state_q == SCAN) && (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (valid_in) state_nx = SCAN;
            SCAN:    if (last) state_nx = DONE;
            DONE:    state_nx = valid_in ? SCAN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        class_valid = (state_q == DONE);
        busy        = (state_q == SCAN);
    end

    always_comb begin
        for (int i = 0; i < NUM_CLASSES; i++) elems[i] = vec_q[i*FP_WIDTH +: FP_WIDTH];
    end
    assign elem = elems[idx_q];

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        best_nx     = best_q;
        best_idx_nx = best_idx_q;
`ifdef ARGMAX_MARGIN_EN
        second_nx   = second_q;
`endif
        if (elem > best_q) begin
            best_nx     = elem;
            best_idx_nx = idx_q;
`ifdef ARGMAX_MARGIN_EN
            second_nx   = best_q;
        end else if (elem > second_q) begin
            second_nx   = elem;
`endif
        end
    end

`ifdef ARGMAX_MARGIN_EN
    // best >= second always, so the modular difference is the true unsigned margin.
    assign margin_nx = {best_nx[FP_WIDTH-1], best_nx} - {second_nx[FP_WIDTH-1], second_nx};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q      <= '0;
            ovf_q      <= 1'b0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
            class_out  <= '0;
            score_out  <= '0;
            class_ovf  <= 1'b0;
            drop_count <= '0;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= '0;
            margin_out <= '0;
`endif
        end else begin
            if (accept) begin
                vec_q      <= values_in;
                ovf_q      <= overflow_in;
                best_q     <= values_in[FP_WIDTH-1:0];
                best_idx_q <= '0;
                idx_q      <= IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
                second_q   <= {1'b1, {(FP_WIDTH-1){1'b0}}};
`endif
            end else if (state_q == SCAN) begin
                best_q     <= best_nx;
                best_idx_q <= best_idx_nx;
`ifdef ARGMAX_MARGIN_EN
                second_q   <= second_nx;
`endif
                if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
            end
            if (last) begin
                class_out  <= best_idx_nx;
                score_out  <= best_nx;
                class_ovf  <= ovf_q;
`ifdef ARGMAX_MARGIN_EN
                margin_out <= margin_nx;
`endif
            end
            if (valid_in && (state_q == SCAN) && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_network_argmax.sv
// Scoreboard bench for network_argmax: directed corner vectors, strobe timing, drop saturation,
// mid-scan reset and random vectors. Build with +define+ARGMAX_MARGIN_EN to cover the margin output.
module tb_network_argmax;
    localparam int EXP_W = 3 + 8 + 1 + 9;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] values_in;
    logic        valid_in;
    logic        overflow_in;
    logic [2:0]  class_out;
    logic [7:0]  score_out;
    logic        class_ovf;
    logic        class_valid;
    logic        busy;
    logic [7:0]  drop_count;
`ifdef ARGMAX_MARGIN_EN
    logic [8:0]  margin_out;
`endif

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int exp_drop = 0;

    network_argmax #(.FP_WIDTH(8), .FP_FRAC(5), .NUM_CLASSES(5)) dut (
        .clk(clk), .rst(rst), .values_in(values_in), .valid_in(valid_in),
        .overflow_in(overflow_in), .class_out(class_out), .score_out(score_out),
        .class_ovf(class_ovf), .class_valid(class_valid), .busy(busy),
`ifdef ARGMAX_MARGIN_EN
        .margin_out(margin_out),
`endif
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [39:0] pack(input logic [7:0] e0, e1, e2, e3, e4);
        return {e4, e3, e2, e1, e0};
    endfunction

    // Reference: whole-vector argmax, then the largest element at any other index.
    function automatic logic [EXP_W-1:0] model(input logic [39:0] v, input logic ovf);
        logic signed [7:0] e, best, sec;
        int bi;
        bit have_sec;
        logic [8:0] margin;
        best = v[7:0];
        bi = 0;
        for (int i = 1; i < 5; i++) begin
            e = v[i*8 +: 8];
            if (e > best) begin best = e; bi = i; end
        end
        have_sec = 0;
        sec = '0;
        for (int i = 0; i < 5; i++) begin
            e = v[i*8 +: 8];
            if (i != bi && (!have_sec || e > sec)) begin sec = e; have_sec = 1; end
        end
        margin = 9'(int'(best) - int'(sec));
        return {3'(bi), best, ovf, margin};
    endfunction

    always @(negedge clk) begin
        if (!rst && class_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                logic [EXP_W-1:0] exp;
                exp = exp_q.pop_front();
                check("class_out", 32'(class_out), 32'(exp[20:18]));
                check("score_out", 32'(score_out), 32'(exp[17:10]));
                check("class_ovf", 32'(class_ovf), 32'(exp[9]));
`ifdef ARGMAX_MARGIN_EN
                check("margin_out", 32'(margin_out), 32'(exp[8:0]));
`endif
            end
        end
    end

    task automatic run_vec(input logic [39:0] v, input logic ovf);
        int lat;
        @(negedge clk);
        values_in   = v;
        overflow_in = ovf;
        valid_in    = 1'b1;
        exp_q.push_back(model(v, ovf));
        lat = 0;
        do begin
            @(negedge clk);
            valid_in = 1'b0;
            lat++;
        end while (!class_valid && lat < 20);
        check("latency", 32'(lat), 32'd5);
    endtask

    task automatic rand_vec(output logic [39:0] v);
        for (int i = 0; i < 5; i++) v[i*8 +: 8] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        logic [39:0] v;
        int p;
        rst = 1'b1; valid_in = 1'b0; overflow_in = 1'b0; values_in = '0;
        repeat (3) @(negedge clk);
        check("rst_class_out", 32'(class_out), 0);
        check("rst_score_out", 32'(score_out), 0);
        check("rst_class_ovf", 32'(class_ovf), 0);
        check("rst_class_valid", 32'(class_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drop_count", 32'(drop_count), 0);
`ifdef ARGMAX_MARGIN_EN
        check("rst_margin_out", 32'(margin_out), 0);
`endif
        rst = 1'b0;

        run_vec(pack(8'h10, 8'h20, 8'hF0, 8'h20, 8'h05), 1'b0);
        run_vec(pack(8'h80, 8'hFF, 8'h90, 8'hC0, 8'hFE), 1'b0);
        run_vec(pack(8'h00, 8'h00, 8'h00, 8'h00, 8'h7F), 1'b1);
        run_vec(pack(8'h01, 8'h02, 8'h03, 8'h04, 8'h05), 1'b0);
`ifdef ARGMAX_MARGIN_EN
        run_vec(pack(8'h7F, 8'h80, 8'h80, 8'h80, 8'h80), 1'b0);
        run_vec(pack(8'h20, 8'h10, 8'h20, 8'h00, 8'h00), 1'b0);
`endif

        // strobes in cycles 0, 2 and 5: the middle one lands in SCAN and is dropped
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("pulse_cv_c%0d", c), 32'(class_valid), 32'(c == 5 || c == 10));
            if (c == 2) check("pulse_busy", 32'(busy), 1);
            if (c == 3) check("pulse_drop", 32'(drop_count), 32'(exp_drop));
            valid_in = (c == 0 || c == 2 || c == 5);
            if (valid_in) begin
                rand_vec(v);
                values_in   = v;
                overflow_in = 1'($urandom_range(0, 1));
                if (c == 2) exp_drop++;
                else exp_q.push_back(model(v, overflow_in));
            end
        end

        // continuous strobe: one accept every 5 cycles, the other four dropped
        p = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            valid_in = 1'b1;
            rand_vec(v);
            values_in   = v;
            overflow_in = 1'($urandom_range(0, 1));
            if (p == 0) exp_q.push_back(model(v, overflow_in));
            else if (exp_drop < 255) exp_drop++;
            p = (p + 1) % 5;
        end
        @(negedge clk);
        valid_in = 1'b0;
        repeat (8) @(negedge clk);
        check("drop_saturate", 32'(drop_count), 32'(exp_drop));
        check("stream_drained", 32'(exp_q.size()), 0);

        // reset in cycle 3 of a scan: result is discarded
        @(negedge clk);
        rand_vec(v);
        values_in = v;
        valid_in  = 1'b1;
        @(negedge clk); valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        exp_drop = 0;
        check("abort_class_out", 32'(class_out), 0);
        check("abort_score_out", 32'(score_out), 0);
        check("abort_class_ovf", 32'(class_ovf), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_drop_count", 32'(drop_count), 32'(exp_drop));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(class_valid), 0);
        end
        run_vec(pack(8'hF0, 8'hF1, 8'h7F, 8'h7F, 8'h80), 1'b1);

        for (int i = 0; i < 10; i++) begin
            rand_vec(v);
            run_vec(v, 1'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk);
        check("final_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
